ifetch_ctrl: RTL and testbench

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

---
 rtl/ifetch_ctrl.sv | 140 ++++++++++++++
 tb/tb_ifetch_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: PC, IF/ID register, HALT drain and halt sequencing.
// Define IFETCH_STATS_EN to add saturating fetch/stall counters (fetch_count_o, stall_count_o).
package mips_pkg;
  localparam int ADDRESSWIDTH = 32;
endpackage

module ifetch_ctrl #(
  parameter int         ADDRESSWIDTH = mips_pkg::ADDRESSWIDTH,
  parameter logic [5:0] HALT_OPCODE  = 6'b010001,
  parameter int         DRAIN_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    stall_i,
  input  logic                    redirect_i,
  input  logic [ADDRESSWIDTH-1:0] redirect_target_i,
  output logic [ADDRESSWIDTH-1:0] imem_addr_o,
  input  logic [31:0]             imem_instr_i,
  output logic [31:0]             if_instr_o,
  output logic [ADDRESSWIDTH-1:0] if_pc_o,
  output logic                    if_valid_o,
  output logic                    halted_o
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]             fetch_count_o,
  output logic [31:0]             stall_count_o
`endif
);

  localparam int AW = ADDRESSWIDTH;
  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   pc, pc_nxt, ifpc_nxt, tgt;
  logic [31:0]     instr_nxt;
  logic            vld_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            unused_tgt_lsbs;

  // Redirect targets are forced word-aligned; the low bits are dropped.
  assign tgt             = {redirect_target_i[AW-1:2], 2'b00};
  assign unused_tgt_lsbs = ^redirect_target_i[1:0];
  assign imem_addr_o     = pc;
  assign halted_o        = (state == HALTED);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = if_instr_o;
    ifpc_nxt  = if_pc_o;
    vld_nxt   = if_valid_o;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (redirect_i) begin
          pc_nxt    = tgt;
          instr_nxt = '0;
          ifpc_nxt  = '0;
          vld_nxt   = 1'b0;
        end else if (!stall_i) begin
          instr_nxt = imem_instr_i;
          ifpc_nxt  = pc;
          vld_nxt   = 1'b1;
          pc_nxt    = pc + AW'(4);
          if (imem_instr_i[31:26] == HALT_OPCODE) begin
            if (DRAIN_CYCLES == 0) begin
              state_nxt = HALTED;
            end else begin
              state_nxt = DRAIN;
              cnt_nxt   = CW'(DRAIN_CYCLES);
            end
          end
        end
      end
      DRAIN: begin
        // A redirect here means the HALT was fetched down a wrong path.
        if (redirect_i) begin
          pc_nxt    = tgt;
          instr_nxt = '0;
          ifpc_nxt  = '0;
          vld_nxt   = 1'b0;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end else if (!stall_i) begin
          instr_nxt = '0;
          ifpc_nxt  = '0;
          vld_nxt   = 1'b0;
          cnt_nxt   = cnt - CW'(1);
          if (cnt == CW'(1)) state_nxt = HALTED;
        end
      end
      HALTED: begin
        instr_nxt = '0;
        ifpc_nxt  = '0;
        vld_nxt   = 1'b0;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= '0;
      if_instr_o <= '0;
      if_pc_o    <= '0;
      if_valid_o <= 1'b0;
      cnt        <= '0;
    end else begin
      pc         <= pc_nxt;
      if_instr_o <= instr_nxt;
      if_pc_o    <= ifpc_nxt;
      if_valid_o <= vld_nxt;
      cnt        <= cnt_nxt;
    end
  end

`ifdef IFETCH_STATS_EN
  logic accept, run_stall;
  assign accept    = (state == RUN) && !redirect_i && !stall_i;
  assign run_stall = (state == RUN) && !redirect_i && stall_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count_o <= '0;
      stall_count_o <= '0;
    end else begin
      if (accept && (fetch_count_o != '1))    fetch_count_o <= fetch_count_o + 32'd1;
      if (run_stall && (stall_count_o != '1)) stall_count_o <= stall_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed pinning checks plus randomized traffic against a behavioural model.
module tb_ifetch_ctrl;
  localparam int         AW  = 32;
  localparam logic [5:0] HOP = 6'b010001;
  localparam int         DC  = 4;

  logic          clk = 1'b0, reset_n = 1'b1, stall_i = 1'b0, redirect_i = 1'b0;
  logic [AW-1:0] redirect_target_i = '0;
  logic [AW-1:0] imem_addr_o, if_pc_o;
  logic [31:0]   imem_instr_i, if_instr_o;
  logic          if_valid_o, halted_o;
`ifdef IFETCH_STATS_EN
  logic [31:0]   fetch_count_o, stall_count_o;
`endif

  logic [AW-1:0] halt_addr = 32'hFFFF_FFFF;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;

  // model state
  logic [AW-1:0] m_pc, m_ifpc;
  logic [31:0]   m_instr, m_fetch, m_stall;
  logic          m_vld;
  bit            m_halted;
  int            m_left;

  ifetch_ctrl dut (
    .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_target_i(redirect_target_i), .imem_addr_o(imem_addr_o),
    .imem_instr_i(imem_instr_i), .if_instr_o(if_instr_o), .if_pc_o(if_pc_o),
    .if_valid_o(if_valid_o), .halted_o(halted_o)
`ifdef IFETCH_STATS_EN
    , .fetch_count_o(fetch_count_o), .stall_count_o(stall_count_o)
`endif
  );

  always #5 clk = ~clk;

  // instruction memory: HALT only at halt_addr, otherwise a non-HALT opcode
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    if (a == halt_addr) return {HOP, a[25:0]};
    return {6'h23, a[25:0] ^ 26'h1579bd};
  endfunction
  assign imem_instr_i = (imem_addr_o == halt_addr) ? {HOP, imem_addr_o[25:0]}
                                                   : {6'h23, imem_addr_o[25:0] ^ 26'h1579bd};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_ifpc = '0; m_instr = '0; m_vld = 0;
    m_halted = 0; m_left = 0; m_fetch = '0; m_stall = '0;
  endtask

  task automatic bubble();
    m_instr = '0; m_ifpc = '0; m_vld = 0;
  endtask

  // one rising edge of the specified behaviour
  task automatic model_edge();
    logic [31:0] w;
    if (m_halted) bubble();
    else if (redirect_i) begin
      m_pc = {redirect_target_i[AW-1:2], 2'b00}; bubble(); m_left = 0;
    end else if (m_left > 0) begin
      if (!stall_i) begin
        bubble(); m_left--;
        if (m_left == 0) m_halted = 1;
      end
    end else if (stall_i) begin
      if (m_stall != 32'hFFFF_FFFF) m_stall++;
    end else begin
      w = mem_word(m_pc);
      m_instr = w; m_ifpc = m_pc; m_vld = 1; m_pc = m_pc + 4;
      if (m_fetch != 32'hFFFF_FFFF) m_fetch++;
      if (w[31:26] == HOP) m_left = DC;
    end
  endtask

  always @(posedge clk) if (reset_n) model_edge();

  // compare process
  always @(negedge clk) if (chk_en) begin
    chk("imem_addr", imem_addr_o, m_pc);
    chk("if_instr",  if_instr_o,  m_instr);
    chk("if_pc",     if_pc_o,     m_ifpc);
    chk("if_valid",  if_valid_o,  m_vld);
    chk("halted",    halted_o,    m_halted);
`ifdef IFETCH_STATS_EN
    chk("fetch_count", fetch_count_o, m_fetch);
    chk("stall_count", stall_count_o, m_stall);
`endif
  end

  task automatic cyc(input bit s, input bit r, input logic [AW-1:0] t);
    stall_i = s; redirect_i = r; redirect_target_i = t;
    @(posedge clk); #2;
  endtask

  // asynchronous reset, checked before any clock edge; returns just after release
  task automatic do_reset(input logic [AW-1:0] ha);
    reset_n = 1'b0; model_reset();
    #1;
    chk("rst_addr",   imem_addr_o, 0);
    chk("rst_halted", halted_o,    0);
    chk("rst_valid",  if_valid_o,  0);
    chk("rst_ifpc",   if_pc_o,     0);
    stall_i = 0; redirect_i = 0; halt_addr = ha;
    @(posedge clk); #2;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] t;
    #1;
    do_reset(32'hFFFF_FFFF);
    chk_en = 1;

    // sequential fetch from reset
    chk("seq_addr0", imem_addr_o, 32'h0);
    cyc(0, 0, 0);
    chk("seq_addr4", imem_addr_o, 32'h4);
    chk("seq_pc0", if_pc_o, 32'h0);
    chk("seq_v0", if_valid_o, 1);
    chk("seq_instr0", if_instr_o, 32'h8C15_79BD);
    cyc(0, 0, 0);
    chk("seq_addr8", imem_addr_o, 32'h8);
    chk("seq_pc4", if_pc_o, 32'h4);

    // three stall cycles at PC 8
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0);
      chk("stall_addr", imem_addr_o, 32'h8);
      chk("stall_ifpc", if_pc_o, 32'h4);
    end
    cyc(0, 0, 0);
    chk("resume_addr", imem_addr_o, 32'hC);
    chk("resume_ifpc", if_pc_o, 32'h8);
`ifdef IFETCH_STATS_EN
    chk("stall_cnt3", stall_count_o, 3);
`endif

    // redirect beats stall, target aligned down
    cyc(1, 1, 32'h42);
    chk("redir_addr", imem_addr_o, 32'h40);
    chk("redir_v", if_valid_o, 0);

    // PC wrap
    cyc(0, 1, 32'hFFFF_FFFE);
    chk("wrap_pre", imem_addr_o, 32'hFFFF_FFFC);
    cyc(0, 0, 0);
    chk("wrap_addr", imem_addr_o, 32'h0);
    chk("wrap_ifpc", if_pc_o, 32'hFFFF_FFFC);

    // HALT at 12: halted on the fourth drain edge
    do_reset(32'hC);
    repeat (4) cyc(0, 0, 0);
    chk("halt_op", if_instr_o[31:26], HOP);
    chk("halt_pc16", imem_addr_o, 32'h10);
    repeat (3) cyc(0, 0, 0);
    chk("drain_not_halted", halted_o, 0);
    cyc(0, 0, 0);
    chk("halted_set", halted_o, 1);
    chk("halted_pc", imem_addr_o, 32'h10);
    chk("halted_v", if_valid_o, 0);
`ifdef IFETCH_STATS_EN
    chk("fetch_cnt4", fetch_count_o, 4);
`endif
    repeat (3) cyc(1, 1, 32'h80);
    chk("halted_sticky", halted_o, 1);
    chk("halted_ignore_redir", imem_addr_o, 32'h10);

    // reset in the middle of DRAIN
    do_reset(32'hC);
    repeat (6) cyc(0, 0, 0);
    do_reset(32'hFFFF_FFFF);
    chk("post_rst_addr", imem_addr_o, 0);
    cyc(0, 0, 0);
    chk("post_rst_fetch0", if_pc_o, 0);
    chk("post_rst_v", if_valid_o, 1);

    // HALT under stall is not accepted
    do_reset(32'h4);
    cyc(0, 0, 0);
    repeat (3) cyc(1, 0, 0);
    chk("halt_stalled_addr", imem_addr_o, 32'h4);
    repeat (6) cyc(0, 0, 0);
    chk("halt_after_stall", halted_o, 1);

    // wrong-path HALT cancelled by redirect
    do_reset(32'h8);
    repeat (3) cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 32'h20);
    chk("cancel_addr", imem_addr_o, 32'h20);
    chk("cancel_v", if_valid_o, 0);
    cyc(0, 0, 0);
    chk("cancel_fetch", if_pc_o, 32'h20);
    chk("cancel_addr24", imem_addr_o, 32'h24);
    repeat (8) cyc(0, 0, 0);
    chk("cancel_no_halt", halted_o, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset({24'h0, 6'($urandom), 2'b00});
      if ($urandom_range(0, 49) == 0) halt_addr = {24'h0, 6'($urandom), 2'b00};
      t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                      : 32'($urandom_range(0, 255));
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, t);
    end

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
